decoder_scan_ctrl: RTL and testbench
====================================

Name: decoder_scan_ctrl

Overview:
Sequencer that sits directly upstream of decoder_nbit and drives its a/enable inputs. It steps a channel index through a programmable range and holds each channel for a programmable dwell time. It inserts one enable-low gap cycle between channels, giving break-before-make on the decoder's one-hot y. It supports single-shot and continuous scans, with range wrap-around through 2**N-1 to 0.

Parameters:
N, 3, index width; must equal the decoder's N (2**N channels)
DWELL_W, 8, width of dwell count

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a scan (sampled in IDLE only)
stop  input  1  abort the scan
continuous  input  1  1 = repeat the range forever, 0 = single pass
dwell  input  DWELL_W  enable-high time per channel, minus 1
first  input  N  first channel of range
last  input  N  last channel of range
a  output  N  channel index to decoder
enable  output  1  decoder enable
busy  output  1  scan in progress
done  output  1  one-cycle pulse at normal single-pass completion
wrap  output  1  one-cycle pulse when a continuous scan restarts at first

Behaviour:
- One clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: a=0, enable=0, busy=0, done=0, wrap=0, state=IDLE, dwell counter=0. Reset mid-scan returns to these values at the next edge.
- FSM states: IDLE, ACTIVE, GAP.
- IDLE: enable=0, busy=0, a holds its last value.
  - start=1 and stop=0: latch first, last, dwell and continuous into internal registers; load a<=first and cnt<=dwell; go to ACTIVE.
  - start and stop together: stay in IDLE.
- ACTIVE: enable=1, busy=1.
  - cnt==0: go to GAP.
  - otherwise: decrement cnt.
  - Result: enable is high for dwell+1 cycles per channel.
- GAP: enable=0, busy=1, exactly one cycle.
  - a != last_q: a<=a+1 modulo 2**N, cnt<=dwell_q, go to ACTIVE.
  - a == last_q with continuous_q=1: a<=first_q, cnt<=dwell_q, wrap=1 for one cycle (coincident with the first ACTIVE cycle), go to ACTIVE.
  - a == last_q with continuous_q=0: go to IDLE; done=1 in the first IDLE cycle.
- stop=1 in ACTIVE or GAP: next cycle state=IDLE, enable=0, busy=0, a holds, done stays 0. Stop has priority over every other transition.
- start while busy: ignored. Input changes while busy: no effect, because latched copies are used.
- Range size: K = ((last - first) mod 2**N) + 1.
  - last < first wraps through 2**N-1 to 0.
  - first == last gives K=1.
  - first = last+1 gives all 2**N channels.
- Timing, with start sampled at edge t0:
  - a=first and enable=1 from cycle t0+1.
  - Each channel takes dwell+2 cycles.
  - Single pass: busy high for cycles t0+1 .. t0+K*(dwell+2); done pulses at t0+K*(dwell+2)+1.
- dwell=0 is legal: enable alternates 1,0 every cycle.
- a changes only on entry to ACTIVE. It is never changed in a cycle where enable=1 is being presented with the previous index, so y never shows two hot bits across channels.

Test Plan:
- N=3, dwell=0, first=0, last=7, continuous=0, start pulse at t0 -> a steps 0..7, enable 1,0 per channel, busy high t0+1..t0+16, done single pulse at t0+17, a remains 7 afterwards.
- dwell=2, first=6, last=1, single pass -> a sequence 6,7,0,1, each with enable high 3 cycles then 1 gap cycle, done at t0+17, no wrap pulse.
- continuous=1, first=2, last=3, dwell=1 -> a=2,2,x,3,3,x,2,...; wrap pulse on each return to 2 (first at t0+7); no done; stop at an arbitrary ACTIVE cycle -> enable=0 and busy=0 next cycle, done=0.
- first=last=5, dwell=4, single -> enable high for 5 cycles with a=5, then 1 gap cycle; done at t0+7.
- Mid-scan changes to first/last/dwell and a second start pulse -> current scan unaffected; start together with stop in IDLE -> stays idle.
- Reset asserted at cycle t0+5 of an active scan -> next cycle a=0, enable=0, busy=0, done=0, wrap=0; a new start afterwards runs normally.

Source files
------------

// File: rtl/decoder_scan_ctrl.sv
// rtl/decoder_scan_ctrl.sv - channel scan sequencer driving decoder_nbit a/enable
// Steps a through a latched range with programmable dwell and a one-cycle enable-low gap.
module decoder_scan_ctrl #(
  parameter int N       = 3,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [N-1:0]       first,
  input  logic [N-1:0]       last,
  output logic [N-1:0]       a,
  output logic               enable,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  localparam logic [N-1:0]       A_ONE   = N'(1);
  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  state_t             state, nxt_state;
  logic [DWELL_W-1:0] cnt, nxt_cnt;
  logic [N-1:0]       nxt_a;
  logic               nxt_done, nxt_wrap, latch;

  logic [N-1:0]       first_q, last_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               continuous_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      a            <= '0;
      enable       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wrap         <= 1'b0;
      first_q      <= '0;
      last_q       <= '0;
      dwell_q      <= '0;
      continuous_q <= 1'b0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      a      <= nxt_a;
      // Outputs are registered views of the state being entered.
      enable <= (nxt_state == ACTIVE);
      busy   <= (nxt_state != IDLE);
      done   <= nxt_done;
      wrap   <= nxt_wrap;
      if (latch) begin
        first_q      <= first;
        last_q       <= last;
        dwell_q      <= dwell;
        continuous_q <= continuous;
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_a     = a;
    nxt_done  = 1'b0;
    nxt_wrap  = 1'b0;
    latch     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          latch     = 1'b1;
          nxt_a     = first;
          nxt_cnt   = dwell;
          nxt_state = ACTIVE;
        end
      end
      ACTIVE: begin
        if (stop) begin
          nxt_state = IDLE;
        end else if (cnt == '0) begin
          nxt_state = GAP;
        end else begin
          nxt_cnt = cnt - CNT_ONE;
        end
      end
      GAP: begin
        // a only moves here, so the decoder never sees a new index while enabled.
        if (stop) begin
          nxt_state = IDLE;
        end else if (a != last_q) begin
          nxt_a     = a + A_ONE;
          nxt_cnt   = dwell_q;
          nxt_state = ACTIVE;
        end else if (continuous_q) begin
          nxt_a     = first_q;
          nxt_cnt   = dwell_q;
          nxt_wrap  = 1'b1;
          nxt_state = ACTIVE;
        end else begin
          nxt_done  = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// tb/tb_decoder_scan_ctrl.sv - directed vector bench for decoder_scan_ctrl
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, continuous;
  logic [7:0] dwell;
  logic [2:0] first, last, a;
  logic       enable, busy, done, wrap;

  int errors = 0;
  int checks = 0;

  decoder_scan_ctrl #(.N(3), .DWELL_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .continuous(continuous), .dwell(dwell), .first(first), .last(last),
    .a(a), .enable(enable), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dwell;
    int first;
    int last;
    int done_at;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " a"}, 32'(a), 0);
    check({tag, " enable"}, 32'(enable), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " wrap"}, 32'(wrap), 0);
  endtask

  task automatic pulse_start(input int c, input int dw, input int f, input int l);
    @(negedge clk);
    continuous = c[0];
    dwell = 8'(dw);
    first = 3'(f);
    last = 3'(l);
    start = 1'b1;
    stop = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Single-pass scan; at cycle 3 all inputs are disturbed and start is re-pulsed.
  task automatic run_vec(input int i);
    int per, idx, ph;
    per = vecs[i].dwell + 2;
    pulse_start(0, vecs[i].dwell, vecs[i].first, vecs[i].last);
    for (int c = 1; c <= vecs[i].done_at; c++) begin
      @(negedge clk);
      if (c < vecs[i].done_at) begin
        idx = (c - 1) / per;
        ph  = (c - 1) % per;
        check($sformatf("v%0d c%0d a", i, c), 32'(a), 32'((vecs[i].first + idx) % 8));
        check($sformatf("v%0d c%0d enable", i, c), 32'(enable), 32'(ph <= vecs[i].dwell));
        check($sformatf("v%0d c%0d busy", i, c), 32'(busy), 1);
        check($sformatf("v%0d c%0d done", i, c), 32'(done), 0);
        check($sformatf("v%0d c%0d wrap", i, c), 32'(wrap), 0);
      end else begin
        check($sformatf("v%0d done pulse", i), 32'(done), 1);
        check($sformatf("v%0d busy end", i), 32'(busy), 0);
        check($sformatf("v%0d enable end", i), 32'(enable), 0);
        check($sformatf("v%0d a end", i), 32'(a), 32'(vecs[i].last));
      end
      if (c == 3) begin
        first = ~first;
        last = ~last;
        dwell = dwell + 8'd3;
        continuous = 1'b1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    check($sformatf("v%0d done one-shot", i), 32'(done), 0);
    check($sformatf("v%0d a holds", i), 32'(a), 32'(vecs[i].last));
    check($sformatf("v%0d idle busy", i), 32'(busy), 0);
  endtask

  // Continuous scan first=2 last=3 dwell=1: period of 6 cycles.
  logic [2:0] cont_a[14]  = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd2,
                              3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd2, 3'd2};
  logic       cont_en[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                              1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    vecs[0] = '{dwell: 0, first: 0, last: 7, done_at: 17};
    vecs[1] = '{dwell: 2, first: 6, last: 1, done_at: 17};
    vecs[2] = '{dwell: 4, first: 5, last: 5, done_at: 7};
    vecs[3] = '{dwell: 1, first: 3, last: 2, done_at: 25};
    vecs[4] = '{dwell: 0, first: 7, last: 0, done_at: 5};

    reset = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    dwell = 8'd0; first = 3'd0; last = 3'd0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i);

    pulse_start(1, 1, 2, 3);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      check($sformatf("cont c%0d a", c), 32'(a), 32'(cont_a[c-1]));
      check($sformatf("cont c%0d enable", c), 32'(enable), 32'(cont_en[c-1]));
      check($sformatf("cont c%0d busy", c), 32'(busy), 1);
      check($sformatf("cont c%0d wrap", c), 32'(wrap), 32'(c == 7 || c == 13));
      check($sformatf("cont c%0d done", c), 32'(done), 0);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop enable", 32'(enable), 0);
    check("stop busy", 32'(busy), 0);
    check("stop done", 32'(done), 0);
    check("stop a holds", 32'(a), 2);
    @(negedge clk);
    check("stop done later", 32'(done), 0);
    check("stop stays idle", 32'(busy), 0);

    start = 1'b1; stop = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("start+stop busy", 32'(busy), 0);
      check("start+stop enable", 32'(enable), 0);
    end
    start = 1'b0; stop = 1'b0;

    pulse_start(0, 2, 0, 7);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("pre-reset c%0d busy", c), 32'(busy), 1);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_zero("mid reset");

    run_vec(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
